mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates a single-port instruction/data memory between the pipelined core's fetch port and its load/store port. The arbiter serialises accesses, holds each transaction stable until the memory acknowledges it, and returns read data with a one-cycle done pulse. It produces stall requests for the fetch and memory stages. It enforces fairness and a per-transaction timeout. It sits between the core's `PC`/`InstrData` and `RWAddress`/`WriteData`/`MemData` ports and the shared memory.

## Interface
- Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- `DATA_WIDTH`, 32, data bus width.
- `ADDR_WIDTH`, 32, address width.
- `MAX_D_STREAK`, 4, maximum consecutive data grants while fetch is pending (≥1).
- `TIMEOUT_CYCLES`, 255, busy cycles without ack before abort; 0 disables the timeout.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; held until `i_done`.
- `i_addr`  in  ADDR_WIDTH  fetch address.
- `i_rdata`  out  DATA_WIDTH  fetched word; valid while `i_done`=1.
- `i_done`  out  1  one-cycle fetch completion pulse.
- `d_req`  in  1  data request; held until `d_done`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_WIDTH  data address.
- `d_wdata`  in  DATA_WIDTH  store data.
- `d_rdata`  out  DATA_WIDTH  load data; valid while `d_done`=1.
- `d_done`  out  1  one-cycle data completion pulse.
- `mem_req`  out  1  memory transaction active.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_rdata`  in  DATA_WIDTH  memory read data; valid with `mem_ack`.
- `mem_ack`  in  1  memory completion; may come any cycle `mem_req`=1.
- `i_stall`  out  1  equals `i_req & ~i_done`, combinational.
- `d_stall`  out  1  equals `d_req & ~d_done`, combinational.
- `err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: effective requests are `i_req & ~i_done` and `d_req & ~d_done`. A requester is ignored in the cycle its done is high, so no false re-grant occurs.
- Grant priority: data wins over fetch, except when `d_streak == MAX_D_STREAK` and fetch is pending; then fetch wins.
- `d_streak` increments on each data grant made while fetch is pending. It clears on any fetch grant and on any data grant with fetch not pending. It saturates at `MAX_D_STREAK`.
- On grant, register `mem_req`=1, `mem_addr`, and `mem_we`/`mem_wdata`. Fetch forces `mem_we`=0 and `mem_wdata`=0. These outputs stay constant for the whole busy period.
- BUSY_x with `mem_ack`=1:
  - Next cycle: `x_done`=1 and `x_rdata` = captured `mem_rdata`. For stores, `d_rdata`=0.
  - `mem_req` drops in that same next cycle; state returns to IDLE.
- Timeout counter `tcnt` clears on grant and increments each busy cycle without ack.
- When `tcnt` reaches `TIMEOUT_CYCLES` (and `TIMEOUT_CYCLES` ≠ 0):
  - Abort: `mem_req` drops, `x_done`=1 with `x_rdata`=0, `err` sets, state returns to IDLE.
  - `err` clears only on reset.
- A `mem_ack` in the same cycle as the timeout reaching its limit counts as success; `err` is not set.
- `mem_ack` while in IDLE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, `d_streak`=0, `tcnt`=0.
- Minimum latency, with request seen in IDLE at cycle 0:
  - Cycle 1: `mem_req`=1.
  - Cycle 1 (if memory acks immediately): `mem_ack`.
  - Cycle 2: done pulse.
- Round trip is therefore 2 + (ack wait) cycles.
- Back-to-back: the cycle a done pulse is high is an IDLE cycle. A different pending requester is granted in that cycle, so its `mem_req` is high in the next cycle.
- Reset asserted mid-transaction: all outputs go to 0 immediately (asynchronous) and the transaction is abandoned. After reset release, requests are re-evaluated from IDLE.
- `i_done`/`d_done` are never high simultaneously.

## Structure
- Shared package `Mem_Arbiter_enum`: state typedef (IDLE, BUSY_I, BUSY_D).
- Sub-module `Timeout_Counter`: clear/enable/limit inputs, `expired` output, width `$clog2(TIMEOUT_CYCLES+1)` (minimum 1).
- Top level contains the FSM, the streak counter, the output registers and the rdata capture registers.

## Test plan
- Single load: `d_req`=1, `d_addr`=0x100, memory acks 3 cycles after `mem_req` with 0xDEADBEEF → `mem_addr`=0x100, `mem_we`=0; `d_done` one cycle with `d_rdata`=0xDEADBEEF; `d_stall` high until then.
- Simultaneous `i_req`/`d_req`, memory zero-wait → data granted first. Fetch is granted in the cycle `d_done` is high; `i_done` follows 2 cycles later.
- Starvation: `d_req` held continuously and `i_req`=1, `MAX_D_STREAK`=4 → 4 data transactions, then 1 fetch, then data resumes.
- Timeout: `TIMEOUT_CYCLES`=8, no ack → `mem_req` drops after 8 busy cycles; `d_done`=1, `d_rdata`=0, `err`=1 and stays 1. Ack arriving on the 8th cycle → normal completion, `err`=0.
- Store: `d_we`=1, `d_addr`=0x40, `d_wdata`=0x12345678 → `mem_we`=1 with address and data held stable until ack; `d_rdata`=0 at done.
- Reset while in BUSY_I → `mem_req`, `i_done` and `err` are 0 immediately. After release with `i_req`=1 → new grant, `mem_req` high 1 cycle later.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// State encoding shared by the memory port arbiter and anything that observes it.
package Mem_Arbiter_enum;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arbState_t;
endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// Busy-cycle watchdog: expired is asserted combinationally in the cycle whose count would reach limit.
// One cycle of lookahead so the abort registers exactly at the limit; limit of 0 never expires.
module Timeout_Counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] limit,
   output logic             expired
);
   logic [WIDTH-1:0] tcnt;
   logic [WIDTH:0]   tcntNext;

   assign tcntNext = {1'b0, tcnt} + {{WIDTH{1'b0}}, 1'b1};
   assign expired  = enable && (limit != '0) && (tcntNext == {1'b0, limit});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt <= '0;
      end else if (clear) begin
         tcnt <= '0;
      end else if (enable) begin
         tcnt <= tcntNext[WIDTH-1:0];
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/load-store arbiter for one shared memory port; request->mem_req 1 cycle, ack->done 1 cycle.
// Requesters hold until their done pulse; data has priority unless it has starved fetch MAX_D_STREAK times.
module mem_port_arbiter
   import Mem_Arbiter_enum::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int MAX_D_STREAK   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [DATA_WIDTH-1:0] i_rdata,
   output logic                  i_done,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_done,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic                  i_stall,
   output logic                  d_stall,
   output logic                  err
);
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);
   localparam logic [SW-1:0] STREAK_MAX    = SW'(MAX_D_STREAK);

   arbState_t     state;
   logic [SW-1:0] dStreak;
   logic          iPend;
   logic          dPend;
   logic          grantI;
   logic          grantD;
   logic          busy;
   logic          tExpired;

   // A requester is masked in its own done cycle so the held request is not re-granted.
   assign iPend   = i_req & ~i_done;
   assign dPend   = d_req & ~d_done;
   assign i_stall = iPend;
   assign d_stall = dPend;
   assign busy    = (state != IDLE);
   assign grantD  = (state == IDLE) & dPend & ~(iPend & (dStreak == STREAK_MAX));
   assign grantI  = (state == IDLE) & iPend & ~grantD;

   Timeout_Counter #(.WIDTH(TW)) uTimeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (grantI | grantD),
      .enable  (busy & ~mem_ack),
      .limit   (TIMEOUT_LIMIT),
      .expired (tExpired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         dStreak   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_done    <= 1'b0;
         d_done    <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         err       <= 1'b0;
      end else begin
         i_done <= 1'b0;
         d_done <= 1'b0;
         case (state)
            IDLE: begin
               if (grantD) begin
                  state     <= BUSY_D;
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  // grantD with fetch pending implies dStreak < MAX, so this never overflows.
                  dStreak   <= iPend ? dStreak + 1'b1 : '0;
               end else if (grantI) begin
                  state     <= BUSY_I;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= i_addr;
                  mem_wdata <= '0;
                  dStreak   <= '0;
               end
            end
            BUSY_I, BUSY_D: begin
               if (mem_ack || tExpired) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (!mem_ack) begin
                     err <= 1'b1;
                  end
                  if (state == BUSY_I) begin
                     i_done  <= 1'b1;
                     i_rdata <= mem_ack ? mem_rdata : '0;
                  end else begin
                     d_done  <= 1'b1;
                     d_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios with constant expectations, then randomized traffic against a behavioural model.
module tb_mem_port_arbiter;
   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int MAXS = 4;
   localparam int TO   = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic [DW-1:0] i_rdata;
   logic          i_done;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [DW-1:0] d_rdata;
   logic          d_done;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ack = 1'b0;
   logic          i_stall;
   logic          d_stall;
   logic          err;

   int checks = 0;
   int errors = 0;

   // behavioural model: who owns the memory, how long it has been busy, what each side sees
   int            mOwner;      // 0 none, 1 fetch, 2 data
   int            mBusy;
   int            mStreak;
   bit            mNew;
   bit            mReq, mWe, mIDone, mDDone, mErr;
   logic [AW-1:0] mAddr;
   logic [DW-1:0] mWdata, mIRdata, mDRdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .i_stall(i_stall), .d_stall(d_stall), .err(err)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic doReset();
      rst = 1'b0;
      i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if ({mem_req, mem_we, i_done, d_done, err, i_stall, d_stall} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=0000000",
                  {mem_req, mem_we, i_done, d_done, err, i_stall, d_stall});
      end
      checks++;
      if (mem_addr !== '0 || mem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_membus got addr=%h wdata=%h exp 0", mem_addr, mem_wdata);
      end
      checks++;
      if (i_rdata !== '0 || d_rdata !== '0) begin
         errors++;
         $display("FAIL reset_rdata got i=%h d=%h exp 0", i_rdata, d_rdata);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single_load();
      bit ok = 1;
      d_req = 1; d_we = 0; d_addr = 32'h100; mem_rdata = 32'h0BAD0BAD; mem_ack = 0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (mem_req !== 1 || mem_addr !== 32'h100 || mem_we !== 0 || d_done !== 0 || d_stall !== 1)
            ok = 0;
         if (k == 4) begin
            mem_ack = 1; mem_rdata = 32'hDEADBEEF;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL load_busy got mem_req=%b addr=%h we=%b d_stall=%b exp 1/100/0/1",
                  mem_req, mem_addr, mem_we, d_stall);
      end
      tick();
      mem_ack = 0; mem_rdata = 32'h55555555;
      checks++;
      if (d_done !== 1 || d_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL load_done got done=%b rdata=%h exp 1/deadbeef", d_done, d_rdata);
      end
      checks++;
      if (mem_req !== 0 || d_stall !== 0) begin
         errors++;
         $display("FAIL load_release got mem_req=%b d_stall=%b exp 0/0", mem_req, d_stall);
      end
      d_req = 0;
      tick();
      checks++;
      if (d_done !== 0 || mem_req !== 0) begin
         errors++;
         $display("FAIL load_pulse got done=%b mem_req=%b exp 0/0", d_done, mem_req);
      end
   endtask

   task automatic test_back_to_back();
      mem_ack = 1; mem_rdata = 32'hCAFE0001;
      i_req = 1; i_addr = 32'h2000; d_req = 1; d_we = 0; d_addr = 32'h300;
      tick();
      checks++;
      if (mem_req !== 1 || mem_addr !== 32'h300 || i_stall !== 1) begin
         errors++;
         $display("FAIL b2b_data_first got mem_req=%b addr=%h i_stall=%b exp 1/300/1",
                  mem_req, mem_addr, i_stall);
      end
      tick();
      checks++;
      if (d_done !== 1 || d_rdata !== 32'hCAFE0001 || i_done !== 0) begin
         errors++;
         $display("FAIL b2b_d_done got d_done=%b d_rdata=%h i_done=%b exp 1/cafe0001/0",
                  d_done, d_rdata, i_done);
      end
      d_req = 0; mem_rdata = 32'hCAFE0002;
      tick();
      checks++;
      if (mem_req !== 1 || mem_addr !== 32'h2000 || mem_we !== 0 || d_done !== 0 || i_done !== 0) begin
         errors++;
         $display("FAIL b2b_fetch_grant got mem_req=%b addr=%h we=%b dd=%b id=%b exp 1/2000/0/0/0",
                  mem_req, mem_addr, mem_we, d_done, i_done);
      end
      tick();
      checks++;
      if (i_done !== 1 || i_rdata !== 32'hCAFE0002) begin
         errors++;
         $display("FAIL b2b_i_done got i_done=%b i_rdata=%h exp 1/cafe0002", i_done, i_rdata);
      end
      i_req = 0; mem_ack = 0;
      tick();
      checks++;
      if (mem_req !== 0 || i_done !== 0) begin
         errors++;
         $display("FAIL b2b_idle got mem_req=%b i_done=%b exp 0/0", mem_req, i_done);
      end
   endtask

   task automatic test_store();
      bit ok = 1;
      d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678;
      mem_rdata = 32'hFFFFFFFF; mem_ack = 0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         if (mem_req !== 1 || mem_we !== 1 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678)
            ok = 0;
         if (k == 3) mem_ack = 1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL store_hold got we=%b addr=%h wdata=%h exp 1/40/12345678",
                  mem_we, mem_addr, mem_wdata);
      end
      tick();
      mem_ack = 0;
      checks++;
      if (d_done !== 1 || d_rdata !== '0) begin
         errors++;
         $display("FAIL store_done got done=%b rdata=%h exp 1/00000000", d_done, d_rdata);
      end
      d_req = 0; d_we = 0;
      tick();
   endtask

   task automatic test_timeout();
      bit ok = 1;
      d_req = 1; d_we = 0; d_addr = 32'h500; mem_rdata = 32'h11111111; mem_ack = 0;
      for (int k = 1; k <= TO; k++) begin
         tick();
         if (mem_req !== 1 || d_done !== 0 || err !== 0) ok = 0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL timeout_busy got mem_req=%b err=%b exp 1/0 for %0d cycles", mem_req, err, TO);
      end
      tick();
      checks++;
      if (mem_req !== 0 || d_done !== 1 || d_rdata !== '0 || err !== 1) begin
         errors++;
         $display("FAIL timeout_abort got mem_req=%b done=%b rdata=%h err=%b exp 0/1/0/1",
                  mem_req, d_done, d_rdata, err);
      end
      d_req = 0;
      for (int k = 0; k < 5; k++) tick();
      checks++;
      if (err !== 1 || d_done !== 0) begin
         errors++;
         $display("FAIL timeout_sticky got err=%b done=%b exp 1/0", err, d_done);
      end
   endtask

   task automatic test_reset_busy();
      i_req = 1; i_addr = 32'h80; mem_ack = 0; mem_rdata = 32'h0F0F0F0F;
      tick();
      tick();
      checks++;
      if (mem_req !== 1 || mem_addr !== 32'h80) begin
         errors++;
         $display("FAIL rstbusy_pre got mem_req=%b addr=%h exp 1/80", mem_req, mem_addr);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (mem_req !== 0 || i_done !== 0 || err !== 0 || mem_addr !== '0) begin
         errors++;
         $display("FAIL rstbusy_async got mem_req=%b i_done=%b err=%b addr=%h exp 0/0/0/0",
                  mem_req, i_done, err, mem_addr);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (mem_req !== 0) begin
         errors++;
         $display("FAIL rstbusy_release got mem_req=%b exp 0", mem_req);
      end
      tick();
      checks++;
      if (mem_req !== 1 || mem_addr !== 32'h80 || mem_we !== 0) begin
         errors++;
         $display("FAIL rstbusy_regrant got mem_req=%b addr=%h we=%b exp 1/80/0",
                  mem_req, mem_addr, mem_we);
      end
      mem_ack = 1;
      tick();
      mem_ack = 0;
      checks++;
      if (i_done !== 1 || i_rdata !== 32'h0F0F0F0F) begin
         errors++;
         $display("FAIL rstbusy_done got i_done=%b i_rdata=%h exp 1/0f0f0f0f", i_done, i_rdata);
      end
      i_req = 0;
      tick();
   endtask

   task automatic test_timeout_ack_edge();
      d_req = 1; d_we = 0; d_addr = 32'h600; mem_rdata = 32'h77777777; mem_ack = 0;
      for (int k = 1; k <= TO; k++) begin
         tick();
         if (k == TO) mem_ack = 1;
      end
      tick();
      mem_ack = 0;
      checks++;
      if (d_done !== 1 || d_rdata !== 32'h77777777 || err !== 0 || mem_req !== 0) begin
         errors++;
         $display("FAIL ack_at_limit got done=%b rdata=%h err=%b mem_req=%b exp 1/77777777/0/0",
                  d_done, d_rdata, err, mem_req);
      end
      d_req = 0;
      tick();
   endtask

   // Applies the arbitration rules for the cycle about to be clocked, using the current inputs.
   task automatic modelStep();
      bit iWant, dWant;
      iWant = i_req && !mIDone;
      dWant = d_req && !mDDone;
      mIDone = 0; mDDone = 0; mNew = 0;
      if (mOwner == 0) begin
         if (dWant && !(iWant && mStreak == MAXS)) begin
            mOwner = 2; mNew = 1; mBusy = 0;
            mReq = 1; mWe = d_we; mAddr = d_addr; mWdata = d_wdata;
            mStreak = iWant ? ((mStreak < MAXS) ? mStreak + 1 : MAXS) : 0;
         end else if (iWant) begin
            mOwner = 1; mNew = 1; mBusy = 0;
            mReq = 1; mWe = 0; mAddr = i_addr; mWdata = '0;
            mStreak = 0;
         end
      end else if (mem_ack || (TO != 0 && mBusy + 1 == TO)) begin
         if (mOwner == 1) begin
            mIDone = 1;
            mIRdata = mem_ack ? mem_rdata : '0;
         end else begin
            mDDone = 1;
            mDRdata = (mem_ack && !mWe) ? mem_rdata : '0;
         end
         if (!mem_ack) mErr = 1;
         mOwner = 0; mReq = 0; mWe = 0;
      end else begin
         mBusy++;
      end
   endtask

   task automatic test_random();
      bit iActive = 0, dActive = 0;
      int busyCnt = 0, delay = 0, r;
      doReset();
      mOwner = 0; mBusy = 0; mStreak = 0; mNew = 0;
      mReq = 0; mWe = 0; mIDone = 0; mDDone = 0; mErr = 0;
      mAddr = '0; mWdata = '0; mIRdata = '0; mDRdata = '0;
      for (int n = 0; n < 4000; n++) begin
         checks++;
         if (mem_req !== mReq || err !== mErr) begin
            errors++;
            if (errors < 20) $display("FAIL rnd_ctrl cyc=%0d got req=%b err=%b exp %b/%b",
                                      n, mem_req, err, mReq, mErr);
         end
         if (mReq) begin
            checks++;
            if (mem_addr !== mAddr || mem_we !== mWe || mem_wdata !== mWdata) begin
               errors++;
               if (errors < 20) $display("FAIL rnd_bus cyc=%0d got %h/%b/%h exp %h/%b/%h",
                                         n, mem_addr, mem_we, mem_wdata, mAddr, mWe, mWdata);
            end
         end
         checks++;
         if (i_done !== mIDone || d_done !== mDDone || (i_done && d_done)) begin
            errors++;
            if (errors < 20) $display("FAIL rnd_done cyc=%0d got i=%b d=%b exp %b/%b",
                                      n, i_done, d_done, mIDone, mDDone);
         end
         if (mIDone) begin
            checks++;
            if (i_rdata !== mIRdata) begin
               errors++;
               if (errors < 20) $display("FAIL rnd_irdata cyc=%0d got %h exp %h", n, i_rdata, mIRdata);
            end
         end
         if (mDDone) begin
            checks++;
            if (d_rdata !== mDRdata) begin
               errors++;
               if (errors < 20) $display("FAIL rnd_drdata cyc=%0d got %h exp %h", n, d_rdata, mDRdata);
            end
         end
         checks++;
         if (i_stall !== (i_req && !mIDone) || d_stall !== (d_req && !mDDone)) begin
            errors++;
            if (errors < 20) $display("FAIL rnd_stall cyc=%0d got %b/%b exp %b/%b", n, i_stall,
                                      d_stall, i_req && !mIDone, d_req && !mDDone);
         end

         // requesters: hold until their own done, then maybe start a new request at once
         if (iActive && mIDone) iActive = 0;
         if (!iActive && $urandom_range(0, 2) != 0) begin
            iActive = 1;
            i_addr = $urandom & 32'hFFFF_FFFC;
         end
         i_req = iActive;
         if (dActive && mDDone) dActive = 0;
         if (!dActive && $urandom_range(0, 2) != 0) begin
            dActive = 1;
            d_we = $urandom_range(0, 1);
            d_addr = $urandom & 32'hFFFF_FFFC;
            d_wdata = $urandom;
         end
         d_req = dActive;

         if (mOwner != 0) begin
            if (mNew) begin
               busyCnt = 0;
               r = $urandom_range(0, 9);
               delay = (r < 7) ? r % 5 : (r == 7) ? TO - 1 : TO + 2;
            end
            mem_ack = (busyCnt == delay);
            busyCnt++;
            mem_rdata = mem_ack ? (mAddr ^ 32'h5A5A_0F0F) : $urandom;
         end else begin
            mem_ack = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
         end

         modelStep();
         tick();
      end
      i_req = 0; d_req = 0; mem_ack = 0;
   endtask

   initial begin
      test_reset();
      test_single_load();
      test_back_to_back();
      test_store();
      test_timeout();
      test_reset_busy();
      test_timeout_ack_edge();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
